imm_gen_pipe: RTL

Registered, parametrised immediate generator for the RISC-V core's decode stage. It decodes the instruction format itself from the opcode, so it needs no external type select. It sign-extends the immediate to XLEN and computes the PC-relative target. Results pass through a valid/ready stage with an optional 2-entry skid buffer, so decode can be pipelined without losing throughput.

---
 rtl/imm_gen_pipe.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/imm_gen_pipe.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen_pipe
// Description : Registered RISC-V immediate generator for the decode stage.
//               The instruction format is derived from the opcode. The
//               immediate is sign-extended to XLEN and the PC-relative
//               target is computed. Both results leave through a valid/ready
//               stage, with an optional 2-entry skid buffer.
//
// Parameters  : XLEN  - datapath width, 32 or 64
//               SKID  - 1: main + skid register (in_ready is registered)
//                       0: single output register (in_ready = !full || drain)
//
// Ports       : clk          in   rising-edge clock
//               rst          in   synchronous active-high reset
//               in_valid     in   in_instr / in_pc valid
//               in_ready     out  block can accept
//               in_instr     in   32-bit instruction word
//               in_pc        in   instruction address (XLEN)
//               out_valid    out  result valid
//               out_ready    in   consumer accepts
//               out_imm      out  sign-extended immediate (XLEN)
//               out_type     out  000 I, 001 S, 010 B, 011 U, 100 J,
//                                 101 R, 111 illegal
//               out_target   out  in_pc + out_imm, modulo 2^XLEN
//               out_illegal  out  unrecognised encoding
//
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter int SKID = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    // Format encodings presented on out_type
    localparam logic [2:0] c_type_i   = 3'b000;
    localparam logic [2:0] c_type_s   = 3'b001;
    localparam logic [2:0] c_type_b   = 3'b010;
    localparam logic [2:0] c_type_u   = 3'b011;
    localparam logic [2:0] c_type_j   = 3'b100;
    localparam logic [2:0] c_type_r   = 3'b101;
    localparam logic [2:0] c_type_ill = 3'b111;

    // Stage payload: {illegal, type, imm, target}
    localparam int c_dw = 2 * XLEN + 4;

    // ------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------
    logic [2:0]      w_type;
    logic            w_illegal;
    logic [31:0]     w_imm32;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_target;
    logic [c_dw-1:0] w_dec;

    always_comb begin
        w_type = c_type_ill;
        case (in_instr[6:0])
            7'b0000011,
            7'b0010011,
            7'b1100111,
            7'b1110011: w_type = c_type_i;
            7'b0011011: if (XLEN == 64) w_type = c_type_i;   // OP-IMM-32
            7'b0100011: w_type = c_type_s;
            7'b1100011: w_type = c_type_b;
            7'b0110111,
            7'b0010111: w_type = c_type_u;
            7'b1101111: w_type = c_type_j;
            7'b0110011: w_type = c_type_r;
            7'b0111011: if (XLEN == 64) w_type = c_type_r;   // OP-32
            default:    w_type = c_type_ill;
        endcase
        // Compressed / non-32-bit encodings are not handled here
        if (in_instr[1:0] != 2'b11) begin
            w_type = c_type_ill;
        end
    end

    assign w_illegal = (w_type == c_type_ill);

    // Every format's immediate fits in 32 bits sign-extended from bit 31,
    // so build the 32-bit value first and widen once afterwards.
    always_comb begin
        w_imm32 = 32'd0;
        case (w_type)
            c_type_i: w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            c_type_s: w_imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                                 in_instr[11:7]};
            c_type_b: w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                 in_instr[30:25], in_instr[11:8], 1'b0};
            c_type_u: w_imm32 = {in_instr[31:12], 12'd0};
            c_type_j: w_imm32 = {{11{in_instr[31]}}, in_instr[31],
                                 in_instr[19:12], in_instr[20],
                                 in_instr[30:21], 1'b0};
            default:  w_imm32 = 32'd0;
        endcase
    end

    assign w_imm    = {{(XLEN-31){w_imm32[31]}}, w_imm32[30:0]};
    assign w_target = in_pc + w_imm;
    assign w_dec    = {w_illegal, w_type, w_imm, w_target};

    // ------------------------------------------------------------------
    // Handshake and output stage
    // ------------------------------------------------------------------
    logic            r_m_valid;
    logic [c_dw-1:0] r_m_data;
    logic            w_in_ready;
    logic            w_acc;
    logic            w_main_load;
    logic            w_main_in_valid;
    logic [c_dw-1:0] w_main_in;

    // Nothing is accepted while reset is held; readiness returns as soon
    // as reset is released.
    assign in_ready    = w_in_ready && !rst;
    assign w_acc       = in_valid && in_ready;
    // Main register may take new content whenever it is empty or draining
    assign w_main_load = !r_m_valid || out_ready;

    generate
        if (SKID != 0) begin : g_skid
            logic            r_s_valid;
            logic [c_dw-1:0] r_s_data;

            // Skid only fills when main is occupied and stalled; it always
            // empties into main on the first edge that main can load.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s_valid <= 1'b0;
                    r_s_data  <= '0;
                end else if (w_main_load) begin
                    r_s_valid <= 1'b0;
                end else if (w_acc) begin
                    r_s_valid <= 1'b1;
                    r_s_data  <= w_dec;
                end
            end

            // Registered readiness: no combinational path from out_ready
            assign w_in_ready      = !r_s_valid;
            // Older skid entry has priority to keep FIFO order
            assign w_main_in_valid = r_s_valid || w_acc;
            assign w_main_in       = r_s_valid ? r_s_data : w_dec;
        end else begin : g_noskid
            assign w_in_ready      = !r_m_valid || out_ready;
            assign w_main_in_valid = w_acc;
            assign w_main_in       = w_dec;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
        end else if (w_main_load) begin
            r_m_valid <= w_main_in_valid;
            if (w_main_in_valid) begin
                r_m_data <= w_main_in;
            end
        end
    end

    assign out_valid = r_m_valid;
    assign {out_illegal, out_type, out_imm, out_target} = r_m_data;

endmodule
`default_nettype wire
